// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the memory access unit: access sizes,
// FSM states, byte-enable constants and alignment/lane functions.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // The reserved size encoding behaves as a word access everywhere.
    function automatic logic is_aligned(input mem_size_t size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: is_aligned = 1'b1;
            SIZE_HALF: is_aligned = ~lane[0];
            default:   is_aligned = (lane == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input mem_size_t size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: lane_be = BE_BYTE << lane;
            SIZE_HALF: lane_be = BE_HALF << {lane[1], 1'b0};
            default:   lane_be = BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input mem_size_t size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: lane_wdata = {4{wdata[7:0]}};
            SIZE_HALF: lane_wdata = {2{wdata[15:0]}};
            default:   lane_wdata = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the memory access unit (master) and memory (slave).
interface mem_access_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load formatter: picks the addressed byte/half lane of the
// read word and zero- or sign-extends it to 32 bits.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  mem_size_t   size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_fill;
    logic        half_fill;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
        byte_fill = sign_ext & byte_sel[7];
        half_fill = sign_ext & half_sel[15];
        case (size)
            SIZE_BYTE: data = {{24{byte_fill}}, byte_sel};
            SIZE_HALF: data = {{16{half_fill}}, half_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one memory op at a time over a req/ack data bus.
// Optional bus-wait timeout with bus_err output under MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_read,
    input  logic              op_write,
    input  mem_size_t         op_size,
    input  logic              op_signed,
    input  logic [31:0]       op_addr,
    input  logic [31:0]       op_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [31:0]       mem_data,
    output logic              addr_err,
`ifdef MEM_ACCESS_TIMEOUT_EN
    output logic              bus_err,
`endif
    mem_access_unit_if.master bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_data_q;
    mem_size_t   size_q;
    logic        signed_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic        req_q;
    logic        done_q;
    logic        flush_pend;
    logic [31:0] load_data;

    logic op_any;
    logic aligned;
    logic accept;
    logic flush_hit;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             bus_err_q;
    assign bus_err = bus_err_q;
`endif

    assign op_any    = op_valid & (op_read | op_write);
    assign aligned   = is_aligned(op_size, op_addr[1:0]);
    assign accept    = (state == ST_IDLE) & op_any & aligned & ~flush & ~reset;
    assign addr_err  = (state == ST_IDLE) & op_any & ~aligned & ~flush & ~reset;
    assign stall     = accept | ((state == ST_REQ) & ~reset);
    assign done      = done_q & ~flush & ~reset;
    assign flush_hit = flush_pend | flush;

    assign mem_data      = mem_data_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_wdata = wdata_q;

    load_extend u_load_extend (
        .rdata    (bus.bus_rdata),
        .lane     (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (signed_q),
        .data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_data_q <= '0;
            size_q     <= SIZE_BYTE;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= BE_NONE;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            flush_pend <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt    <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            bus_err_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_REQ;
                        req_q      <= 1'b1;
                        addr_q     <= op_addr;
                        size_q     <= op_size;
                        signed_q   <= op_signed;
                        we_q       <= op_write & ~op_read;
                        be_q       <= lane_be(op_size, op_addr[1:0]);
                        wdata_q    <= lane_wdata(op_size, op_wdata);
                        flush_pend <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack) begin
                        req_q      <= 1'b0;
                        flush_pend <= 1'b0;
                        // A flushed op still finishes on the bus but reports nothing.
                        if (flush_hit) begin
                            state <= ST_IDLE;
                        end else begin
                            state      <= ST_DONE;
                            done_q     <= 1'b1;
                            mem_data_q <= we_q ? 32'h0 : load_data;
                        end
                    end else begin
                        if (flush) begin
                            flush_pend <= 1'b1;
                        end
`ifdef MEM_ACCESS_TIMEOUT_EN
                        if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            state      <= ST_IDLE;
                            req_q      <= 1'b0;
                            flush_pend <= 1'b0;
                            bus_err_q  <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed loads/stores, misalignment,
// flush, reset abort, randomized back-to-back ops and (if enabled) bus timeout.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_read = 1'b0;
    logic        op_write = 1'b0;
    mem_size_t   op_size = SIZE_WORD;
    logic        op_signed = 1'b0;
    logic [31:0] op_addr = '0;
    logic [31:0] op_wdata = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        done;
    logic [31:0] mem_data;
    logic        addr_err;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic        bus_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_read  (op_read),
        .op_write (op_write),
        .op_size  (op_size),
        .op_signed(op_signed),
        .op_addr  (op_addr),
        .op_wdata (op_wdata),
        .flush    (flush),
        .stall    (stall),
        .done     (done),
        .mem_data (mem_data),
        .addr_err (addr_err),
`ifdef MEM_ACCESS_TIMEOUT_EN
        .bus_err  (bus_err),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int          stall_cnt;
        int          last_stall;
        int          done_cnt;
        int          done_cycle;
        int          req_cnt;
        int          last_req;
        int          addr_err_cnt;
        int          unstable;
        int          bus_err_cycle;
        logic [3:0]  be;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
    } obs_t;

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] lane,
                                               input mem_size_t sz, input logic sg);
        logic [31:0] sh;
        sh = rd >> (lane * 8);
        if (sz == SIZE_BYTE) return (sg && sh[7]) ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
        if (sz == SIZE_HALF) return (sg && sh[15]) ? (sh | 32'hFFFF_0000) : (sh & 32'h0000_FFFF);
        return rd;
    endfunction

    function automatic logic [3:0] model_be(input mem_size_t sz, input logic [1:0] lane);
        if (sz == SIZE_BYTE) return 4'b0001 << lane;
        if (sz == SIZE_HALF) return lane[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input mem_size_t sz, input logic [31:0] wd);
        if (sz == SIZE_BYTE) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (sz == SIZE_HALF) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    // Presents one op at cycle 0, acks on REQ cycle ack_wait+1, flushes at flush_cyc,
    // and records what the DUT did cycle by cycle.
    task automatic issue_op(input logic rd, input logic wr, input mem_size_t sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wd, input int ack_wait,
                            input logic [31:0] rdata, input int flush_cyc, output obs_t o);
        int ncyc;
        ncyc = ack_wait + 5;
        if (ncyc > 12) ncyc = 12;
        o.stall_cnt = 0; o.last_stall = -1; o.done_cnt = 0; o.done_cycle = -1;
        o.req_cnt = 0; o.last_req = -1; o.addr_err_cnt = 0; o.unstable = 0;
        o.bus_err_cycle = -1; o.be = 'x; o.we = 'x; o.addr = 'x; o.wdata = 'x; o.data = 'x;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            op_valid = (c == 0); op_read = rd; op_write = wr; op_size = sz;
            op_signed = sg; op_addr = addr; op_wdata = wd;
            flush = (c == flush_cyc);
            bus.bus_ack = (c == ack_wait + 1);
            bus.bus_rdata = (c == ack_wait + 1) ? rdata : 32'h0;
            @(negedge clk);
            if (stall) begin o.stall_cnt++; o.last_stall = c; end
            if (addr_err) o.addr_err_cnt++;
            if (done) begin
                o.done_cnt++;
                if (o.done_cycle < 0) begin o.done_cycle = c; o.data = mem_data; end
            end
            if (bus.bus_req) begin
                if (o.req_cnt == 0) begin
                    o.be = bus.bus_be; o.we = bus.bus_we; o.addr = bus.bus_addr; o.wdata = bus.bus_wdata;
                end else if ({bus.bus_be, bus.bus_we, bus.bus_addr, bus.bus_wdata} !== {o.be, o.we, o.addr, o.wdata}) begin
                    o.unstable++;
                end
                o.req_cnt++; o.last_req = c;
            end
`ifdef MEM_ACCESS_TIMEOUT_EN
            if (bus_err && o.bus_err_cycle < 0) o.bus_err_cycle = c;
`endif
        end
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0; bus.bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL rst_addr_err got %b want 0", addr_err); end
        n_cmp++; if (bus.bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_bus_req got %b want 0", bus.bus_req); end
        n_cmp++; if (bus.bus_we !== 1'b0) begin n_bad++; $display("FAIL rst_bus_we got %b want 0", bus.bus_we); end
        n_cmp++; if (bus.bus_be !== 4'b0000) begin n_bad++; $display("FAIL rst_bus_be got %b want 0000", bus.bus_be); end
        n_cmp++; if (mem_data !== 32'h0) begin n_bad++; $display("FAIL rst_mem_data got %h want 0", mem_data); end
        n_cmp++; if (bus.bus_addr !== 32'h0) begin n_bad++; $display("FAIL rst_bus_addr got %h want 0", bus.bus_addr); end
        n_cmp++; if (bus.bus_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_bus_wdata got %h want 0", bus.bus_wdata); end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_load_word();
        obs_t o;
        logic [31:0] exp;
        exp_q.push_back(32'hDEAD_BEEF);
        issue_op(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0, 0, 32'hDEAD_BEEF, -1, o);
        n_cmp++; if (o.be !== 4'b1111) begin n_bad++; $display("FAIL lw_be got %b want 1111", o.be); end
        n_cmp++; if (o.addr !== 32'h1000) begin n_bad++; $display("FAIL lw_addr got %h want 1000", o.addr); end
        n_cmp++; if (o.we !== 1'b0) begin n_bad++; $display("FAIL lw_we got %b want 0", o.we); end
        n_cmp++; if (o.done_cycle !== 2) begin n_bad++; $display("FAIL lw_done_cycle got %0d want 2", o.done_cycle); end
        n_cmp++; if (o.stall_cnt !== 2) begin n_bad++; $display("FAIL lw_stall_cycles got %0d want 2", o.stall_cnt); end
        exp = exp_q.pop_front();
        n_cmp++; if (o.data !== exp) begin n_bad++; $display("FAIL lw_mem_data got %h want %h", o.data, exp); end
    endtask

    task automatic test_load_byte_half();
        obs_t o;
        logic [31:0] exp;
        exp_q.push_back(model_load(32'h80FF_FF7F, 2'd3, SIZE_BYTE, 1'b1));
        issue_op(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h1003, 32'h0, 0, 32'h80FF_FF7F, -1, o);
        n_cmp++; if (o.be !== 4'b1000) begin n_bad++; $display("FAIL lb_be got %b want 1000", o.be); end
        exp = exp_q.pop_front();
        n_cmp++; if (o.data !== exp || exp !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_mem_data got %h want ffffff80", o.data); end

        exp_q.push_back(model_load(32'h80FF_FF7F, 2'd3, SIZE_BYTE, 1'b0));
        issue_op(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h1003, 32'h0, 0, 32'h80FF_FF7F, -1, o);
        exp = exp_q.pop_front();
        n_cmp++; if (o.data !== exp || exp !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_mem_data got %h want 00000080", o.data); end

        exp_q.push_back(model_load(32'h80FF_FF7F, 2'd2, SIZE_HALF, 1'b1));
        issue_op(1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h1002, 32'h0, 1, 32'h80FF_FF7F, -1, o);
        n_cmp++; if (o.be !== 4'b1100) begin n_bad++; $display("FAIL lh_be got %b want 1100", o.be); end
        exp = exp_q.pop_front();
        n_cmp++; if (o.data !== exp) begin n_bad++; $display("FAIL lh_mem_data got %h want %h", o.data, exp); end

        // Read and write both asserted behaves as a read.
        exp_q.push_back(32'h1357_9BDF);
        issue_op(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h1010, 32'hFFFF_FFFF, 0, 32'h1357_9BDF, -1, o);
        n_cmp++; if (o.we !== 1'b0) begin n_bad++; $display("FAIL rw_both_we got %b want 0", o.we); end
        exp = exp_q.pop_front();
        n_cmp++; if (o.data !== exp) begin n_bad++; $display("FAIL rw_both_mem_data got %h want %h", o.data, exp); end
    endtask

    task automatic test_store();
        obs_t o;
        logic [31:0] exp;
        exp_q.push_back(32'h0);
        issue_op(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h2002, 32'h0000_ABCD, 3, 32'h5555_5555, -1, o);
        n_cmp++; if (o.be !== 4'b1100) begin n_bad++; $display("FAIL sh_be got %b want 1100", o.be); end
        n_cmp++; if (o.wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata got %h want abcdabcd", o.wdata); end
        n_cmp++; if (o.we !== 1'b1) begin n_bad++; $display("FAIL sh_we got %b want 1", o.we); end
        n_cmp++; if (o.addr !== 32'h2000) begin n_bad++; $display("FAIL sh_addr got %h want 2000", o.addr); end
        n_cmp++; if (o.stall_cnt !== 5) begin n_bad++; $display("FAIL sh_stall_cycles got %0d want 5", o.stall_cnt); end
        n_cmp++; if (o.done_cycle !== 5) begin n_bad++; $display("FAIL sh_done_cycle got %0d want 5", o.done_cycle); end
        n_cmp++; if (o.req_cnt !== 4 || o.unstable !== 0) begin n_bad++; $display("FAIL sh_req_hold got %0d cycles/%0d changes want 4/0", o.req_cnt, o.unstable); end
        exp = exp_q.pop_front();
        n_cmp++; if (o.data !== exp) begin n_bad++; $display("FAIL sh_mem_data got %h want %h", o.data, exp); end

        exp_q.push_back(32'h0);
        issue_op(1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h3001, 32'h1234_565A, 0, 32'h0, -1, o);
        n_cmp++; if (o.be !== 4'b0010) begin n_bad++; $display("FAIL sb_be got %b want 0010", o.be); end
        n_cmp++; if (o.wdata !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL sb_wdata got %h want 5a5a5a5a", o.wdata); end
        exp = exp_q.pop_front();
        n_cmp++; if (o.data !== exp) begin n_bad++; $display("FAIL sb_mem_data got %h want %h", o.data, exp); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        // An ack arriving while idle must also be ignored.
        issue_op(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h1002, 32'h0, 0, 32'hFFFF_FFFF, -1, o);
        n_cmp++; if (o.addr_err_cnt !== 1) begin n_bad++; $display("FAIL lw_mis_addr_err got %0d want 1", o.addr_err_cnt); end
        n_cmp++; if (o.req_cnt !== 0) begin n_bad++; $display("FAIL lw_mis_bus_req got %0d want 0", o.req_cnt); end
        n_cmp++; if (o.stall_cnt !== 0) begin n_bad++; $display("FAIL lw_mis_stall got %0d want 0", o.stall_cnt); end
        n_cmp++; if (o.done_cnt !== 0) begin n_bad++; $display("FAIL lw_mis_done got %0d want 0", o.done_cnt); end
        issue_op(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h2001, 32'h0, 0, 32'h0, -1, o);
        n_cmp++; if (o.addr_err_cnt !== 1 || o.req_cnt !== 0) begin n_bad++; $display("FAIL sh_mis got err %0d req %0d want 1/0", o.addr_err_cnt, o.req_cnt); end
    endtask

    task automatic test_flush();
        obs_t o;
        logic [31:0] exp;
        exp_q.push_back(32'h1234_5678);
        issue_op(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h1004, 32'h0, 0, 32'h1234_5678, -1, o);
        exp = exp_q.pop_front();
        n_cmp++; if (o.data !== exp) begin n_bad++; $display("FAIL fl_pre_mem_data got %h want %h", o.data, exp); end
        issue_op(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h1008, 32'h0, 3, 32'hCAFE_F00D, 2, o);
        n_cmp++; if (o.last_req !== 4 || o.req_cnt !== 4) begin n_bad++; $display("FAIL fl_req_hold got last %0d cnt %0d want 4/4", o.last_req, o.req_cnt); end
        n_cmp++; if (o.done_cnt !== 0) begin n_bad++; $display("FAIL fl_done got %0d want 0", o.done_cnt); end
        n_cmp++; if (o.last_stall !== 4) begin n_bad++; $display("FAIL fl_idle_at_5 got last stall %0d want 4", o.last_stall); end
        n_cmp++; if (mem_data !== exp) begin n_bad++; $display("FAIL fl_mem_data_kept got %h want %h", mem_data, exp); end
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_size = SIZE_WORD; op_addr = 32'h4000;
        @(posedge clk); #1;
        op_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        n_cmp++; if (bus.bus_req !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_abort got req %b stall %b want 0/0", bus.bus_req, stall); end
        @(posedge clk); #1; bus.bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || mem_data !== 32'h0) begin n_bad++; $display("FAIL rst_mid_done got done %b data %h want 0/0", done, mem_data); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) begin
            mem_size_t sz;
            logic [1:0] lane;
            logic wr, sg;
            logic [31:0] addr, wd, rd;
            int w;
            sz = mem_size_t'($urandom_range(0, 2));
            lane = 2'($urandom_range(0, 3));
            if (sz == SIZE_HALF) lane[0] = 1'b0;
            if (sz == SIZE_WORD) lane = 2'b00;
            wr = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            addr = ($urandom() & 32'hFFFF_FFFC) | {30'h0, lane};
            wd = $urandom(); rd = $urandom(); w = $urandom_range(0, 3);
            exp_q.push_back(wr ? 32'h0 : model_load(rd, lane, sz, sg));
            issue_op(~wr, wr, sz, sg, addr, wd, w, rd, -1, o);
            n_cmp++; if (o.done_cycle !== w + 2 || o.stall_cnt !== w + 2) begin n_bad++; $display("FAIL b2b%0d_timing got done %0d stall %0d want %0d", i, o.done_cycle, o.stall_cnt, w + 2); end
            n_cmp++; if (o.be !== model_be(sz, lane) || o.we !== wr) begin n_bad++; $display("FAIL b2b%0d_be_we got %b/%b want %b/%b", i, o.be, o.we, model_be(sz, lane), wr); end
            n_cmp++; if (o.addr !== (addr & 32'hFFFF_FFFC) || o.wdata !== model_wdata(sz, wd)) begin n_bad++; $display("FAIL b2b%0d_addr_wdata got %h/%h want %h/%h", i, o.addr, o.wdata, addr & 32'hFFFF_FFFC, model_wdata(sz, wd)); end
            exp = exp_q.pop_front();
            n_cmp++; if (o.data !== exp) begin n_bad++; $display("FAIL b2b%0d_mem_data got %h want %h", i, o.data, exp); end
        end
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        issue_op(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h5000, 32'h0, 20, 32'h0, -1, o);
        n_cmp++; if (o.bus_err_cycle !== 5) begin n_bad++; $display("FAIL tmo_bus_err_cycle got %0d want 5", o.bus_err_cycle); end
        n_cmp++; if (o.last_req !== 4 || o.req_cnt !== 4) begin n_bad++; $display("FAIL tmo_req got last %0d cnt %0d want 4/4", o.last_req, o.req_cnt); end
        n_cmp++; if (o.done_cnt !== 0) begin n_bad++; $display("FAIL tmo_done got %0d want 0", o.done_cnt); end
    endtask
`else
    task automatic test_long_wait();
        obs_t o;
        logic [31:0] exp;
        exp_q.push_back(32'h0BAD_F00D);
        issue_op(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h5000, 32'h0, 8, 32'h0BAD_F00D, -1, o);
        n_cmp++; if (o.done_cycle !== 10 || o.req_cnt !== 9) begin n_bad++; $display("FAIL long_wait got done %0d req %0d want 10/9", o.done_cycle, o.req_cnt); end
        exp = exp_q.pop_front();
        n_cmp++; if (o.data !== exp) begin n_bad++; $display("FAIL long_wait_mem_data got %h want %h", o.data, exp); end
    endtask
`endif

    initial begin
        bus.bus_ack = 1'b0;
        bus.bus_rdata = '0;
        test_reset();
        test_load_word();
        test_load_byte_half();
        test_store();
        test_misaligned();
        test_flush();
        test_reset_mid_req();
        test_back_to_back();
`ifdef MEM_ACCESS_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, bus-wait cycles before timeout error (used only with REQ-027 macro).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op_valid  in  1  pipeline presents a memory op this cycle.
REQ-005 op_read / op_write  in  1 each  load / store; both high is illegal, treated as read.
REQ-006 op_size  in  2  mem_size_t: BYTE, HALF, WORD.
REQ-007 op_signed  in  1  sign-extend load result.
REQ-008 op_addr / op_wdata  in  32 each  effective address / store data (low-aligned).
REQ-009 flush  in  1  nullify pending op result.
REQ-010 stall  out  1  hold upstream pipeline.
REQ-011 done / mem_data  out  1 / 32  result-valid pulse / extended load data.
REQ-012 addr_err  out  1  one-cycle misaligned-access pulse.
REQ-013 bus_req, bus_we, bus_be, bus_addr, bus_wdata  out  1,1,4,32,32  data-bus request; bus_addr word-aligned (bits[1:0]=0).
REQ-014 bus_ack / bus_rdata  in  1 / 32  request accepted and completed / read data valid with ack.

Function
REQ-015 FSM states IDLE, REQ, DONE; IDLE->REQ on accepted op; REQ->DONE on bus_ack; DONE->IDLE unconditionally.
REQ-016 Op accepted in IDLE when op_valid & (op_read|op_write) & aligned; addr, size, signed, we, be, lane-shifted wdata registered at acceptance.
REQ-017 Aligned: WORD needs addr[1:0]=0, HALF needs addr[0]=0, BYTE always.
REQ-018 Misaligned op in IDLE: addr_err=1 for that cycle, no bus_req, stall=0, state stays IDLE.
REQ-019 bus_be: WORD 1111; HALF 0011<<addr[1]*2; BYTE 0001<<addr[1:0]; bus_wdata replicates byte/half across lanes.
REQ-020 bus_req=1 throughout REQ, registered, stable (addr/be/we/wdata unchanged) until cycle of bus_ack inclusive.
REQ-021 Load: selected lane of bus_rdata captured on ack, zero- or sign-extended to 32 bits into mem_data; store: mem_data=0.
REQ-022 stall=1 in acceptance cycle and all REQ cycles; 0 in IDLE without accept and in DONE.
REQ-023 done=1 only in DONE; latency acceptance->done = 2 cycles plus bus wait (ack on first REQ cycle -> done at cycle 2).
REQ-024 flush in REQ: bus transaction still completes (req held to ack), then DONE suppressed (done=0, mem_data unchanged), return to IDLE; flush in IDLE blocks acceptance; flush in DONE clears done that cycle.
REQ-025 bus_ack outside REQ ignored.

Reset
REQ-026 Reset: state IDLE, stall/done/addr_err/bus_req/bus_we=0, bus_be=0000, mem_data/bus_addr/bus_wdata=0; reset mid-REQ abandons transaction immediately.

Configuration
REQ-027 Macro MEM_ACCESS_TIMEOUT_EN defined: counter clears on REQ entry, increments per REQ cycle without ack; at TIMEOUT_CYCLES drops bus_req, pulses output bus_err (1 bit, extra port), returns IDLE with done=0; undefined: no counter, no bus_err port, REQ waits indefinitely.

Structure
REQ-028 Package mem_access_pkg holds mem_size_t, state enum, lane/be constants.
REQ-029 Sub-module load_extend (lane select + sign/zero extension, combinational) instantiated once.

Verification
REQ-030 LW addr 0x1000, ack on first REQ cycle, rdata 0xDEADBEEF -> bus_be 1111, done at cycle 2, mem_data 0xDEADBEEF, stall 2 cycles.
REQ-031 LB signed addr 0x1003, rdata 0x80FF_FF7F -> be 1000, mem_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr 0x2002, wdata 0x0000ABCD, ack after 3 wait cycles -> be 1100, bus_wdata 0xABCDABCD, bus_we 1, stall 5 cycles, done cycle 5.
REQ-033 LW addr 0x1002 -> addr_err 1 cycle, bus_req never rises, stall 0.
REQ-034 LW, flush in second REQ cycle, ack cycle 4 -> bus_req held to ack, done never pulses, IDLE cycle 5.
REQ-035 With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err pulse after 4 REQ cycles, bus_req 0, done 0.
